fetch_seq: RTL and testbench



---
 rtl/fetch_seq.sv | 95 +++++++++
 tb/tb_fetch_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch/sequencing stage: owns pc, latches ROM opcode, resolves JMP/JNZ locally, issues others to execute.
// Branch costs 2 cycles, non-branch >= 4; holds ir in ISSUE until ex_ready, waits in WAIT for ex_done.
module fetch_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  pc,
  input  logic [15:0] op_in,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ex_ready,
  input  logic        ex_done,
  input  logic        nz_flag,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [3:0] JMP_OP = 4'hA;
  localparam logic [3:0] JNZ_OP = 4'hB;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0] state;

  // Outputs decode from state only, so no input reaches an output combinationally.
  assign ir_valid = (state == S_ISSUE);
  assign halted   = (state == S_HALT);
  assign busy     = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= 8'h00;
      ir      <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= 8'h00;
            retired <= 16'h0000;
          end
        end
        S_FETCH: begin
          ir    <= op_in;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (ir[15:12])
            JMP_OP: begin
              // A jump to its own address is the program's terminal instruction.
              if (ir[7:0] == pc) begin
                state <= S_HALT;
              end else begin
                pc    <= ir[7:0];
                state <= S_FETCH;
              end
            end
            JNZ_OP: begin
              pc    <= nz_flag ? ir[7:0] : pc + 8'd1;
              state <= S_FETCH;
            end
            default: state <= S_ISSUE;
          endcase
        end
        S_ISSUE: begin
          if (ex_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (ex_done) begin
            pc    <= pc + 8'd1;
            state <= S_FETCH;
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
          end
        end
        S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= 8'h00;
            retired <= 16'h0000;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle vector table plus hand-written wrap/reset sequence.
module tb_fetch_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc;
  logic [15:0] op_in;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ex_ready = 1'b0;
  logic        ex_done = 1'b0;
  logic        nz_flag = 1'b0;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  logic [15:0] rom [0:255];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign op_in = rom[pc];

  fetch_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc       (pc),
    .op_in    (op_in),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ex_ready (ex_ready),
    .ex_done  (ex_done),
    .nz_flag  (nz_flag),
    .busy     (busy),
    .halted   (halted),
    .retired  (retired)
  );

  typedef struct {
    logic        rst, start, rdy, done, nz;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        v, busy, halt;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic d, logic n,
                              logic [7:0] p, logic [15:0] i, logic v,
                              logic b, logic h, logic [15:0] rt);
    vec_t t;
    t.rst = r; t.start = s; t.rdy = rd; t.done = d; t.nz = n;
    t.pc = p; t.ir = i; t.v = v; t.busy = b; t.halt = h; t.ret = rt;
    return t;
  endfunction

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(string tag, logic [7:0] p, logic [15:0] i, logic v,
                       logic b, logic h, logic [15:0] rt);
    cmp({tag, ".pc"}, {8'h00, pc}, {8'h00, p});
    cmp({tag, ".ir"}, ir, i);
    cmp({tag, ".ir_valid"}, {15'h0, ir_valid}, {15'h0, v});
    cmp({tag, ".busy"}, {15'h0, busy}, {15'h0, b});
    cmp({tag, ".halted"}, {15'h0, halted}, {15'h0, h});
    cmp({tag, ".retired"}, retired, rt);
  endtask

  task automatic step(logic r, logic s, logic rd, logic d, logic n);
    rst = r; start = s; ex_ready = rd; ex_done = d; nz_flag = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[0]     = 16'h1230;
    rom[1]     = 16'h1340;
    rom[2]     = 16'h1450;
    rom[3]     = 16'h1560;
    rom[4]     = 16'hB05C;
    rom[5]     = 16'hA04D;
    rom[8'h5C] = 16'hA004;
    rom[77]    = 16'hA04D;
    rom[8'hFF] = 16'h1777;

    // Reset and idle
    vecs.push_back(mk(1,0,0,0,0, 8'h00, 16'h0000, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 8'h00, 16'h0000, 0,0,0, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,0,0,0, 8'h00, 16'h0000, 0,0,0, 0));
    // Linear issue: FETCH, DECODE, ISSUE, WAIT per instruction
    vecs.push_back(mk(0,1,1,0,0, 8'h00, 16'h0000, 0,1,0, 0));
    vecs.push_back(mk(0,0,1,0,0, 8'h00, 16'h1230, 0,1,0, 0));
    vecs.push_back(mk(0,0,1,0,0, 8'h00, 16'h1230, 1,1,0, 0));
    vecs.push_back(mk(0,0,1,0,0, 8'h00, 16'h1230, 0,1,0, 0));
    vecs.push_back(mk(0,0,1,1,0, 8'h01, 16'h1230, 0,1,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 8'h01, 16'h1340, 0,1,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 8'h01, 16'h1340, 1,1,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 8'h01, 16'h1340, 0,1,0, 1));
    vecs.push_back(mk(0,0,1,1,0, 8'h02, 16'h1340, 0,1,0, 2));
    vecs.push_back(mk(0,0,1,0,0, 8'h02, 16'h1450, 0,1,0, 2));
    vecs.push_back(mk(0,0,1,0,0, 8'h02, 16'h1450, 1,1,0, 2));
    vecs.push_back(mk(0,1,1,0,0, 8'h02, 16'h1450, 0,1,0, 2));
    vecs.push_back(mk(0,0,1,1,0, 8'h03, 16'h1450, 0,1,0, 3));
    // Backpressure: five stalled ISSUE cycles, stray ex_done and start ignored
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 0,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,1,0,0,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,0,0,1,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 1,1,0, 3));
    vecs.push_back(mk(0,0,1,0,0, 8'h03, 16'h1560, 0,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 8'h03, 16'h1560, 0,1,0, 3));
    vecs.push_back(mk(0,0,0,1,0, 8'h04, 16'h1560, 0,1,0, 4));
    // JNZ taken to 5C, JMP back to 4, JNZ not taken to 5, JMP 77, self-jump halt
    vecs.push_back(mk(0,0,1,0,0, 8'h04, 16'hB05C, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,1, 8'h5C, 16'hB05C, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h5C, 16'hA004, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h04, 16'hA004, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,1, 8'h04, 16'hB05C, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h05, 16'hB05C, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h05, 16'hA04D, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h4D, 16'hA04D, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h4D, 16'hA04D, 0,1,0, 4));
    vecs.push_back(mk(0,0,1,0,0, 8'h4D, 16'hA04D, 0,0,1, 4));
    vecs.push_back(mk(0,0,1,1,0, 8'h4D, 16'hA04D, 0,0,1, 4));
    // Restart from HALT
    vecs.push_back(mk(0,1,0,0,0, 8'h00, 16'hA04D, 0,1,0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].rst, vecs[n].start, vecs[n].rdy, vecs[n].done, vecs[n].nz);
      check($sformatf("vec%0d", n), vecs[n].pc, vecs[n].ir, vecs[n].v,
            vecs[n].busy, vecs[n].halt, vecs[n].ret);
    end

    // Wrap: JMP FF, non-branch at FF completes and pc wraps to 00
    rom[0] = 16'hA0FF;
    step(0,0,0,0,0); check("wrap_dec",    8'h00, 16'hA0FF, 0,1,0, 0);
    step(0,0,0,0,0); check("wrap_jmp",    8'hFF, 16'hA0FF, 0,1,0, 0);
    step(0,0,0,0,0); check("wrap_fetch",  8'hFF, 16'h1777, 0,1,0, 0);
    step(0,0,0,0,0); check("wrap_issue",  8'hFF, 16'h1777, 1,1,0, 0);
    step(0,0,1,1,0); check("wrap_acc",    8'hFF, 16'h1777, 0,1,0, 0);
    step(0,0,0,0,0); check("wrap_wait",   8'hFF, 16'h1777, 0,1,0, 0);
    step(0,0,0,1,0); check("wrap_done",   8'h00, 16'h1777, 0,1,0, 1);
    // Reset during WAIT, then a late ex_done in IDLE
    step(0,0,0,0,0); check("rw_dec",      8'h00, 16'hA0FF, 0,1,0, 1);
    step(0,0,0,0,0); check("rw_jmp",      8'hFF, 16'hA0FF, 0,1,0, 1);
    step(0,0,0,0,0); check("rw_fetch",    8'hFF, 16'h1777, 0,1,0, 1);
    step(0,0,0,0,0); check("rw_issue",    8'hFF, 16'h1777, 1,1,0, 1);
    step(0,0,1,0,0); check("rw_acc",      8'hFF, 16'h1777, 0,1,0, 1);
    step(1,0,0,0,0); check("rw_reset",    8'h00, 16'h0000, 0,0,0, 0);
    step(0,0,0,1,0); check("late_done",   8'h00, 16'h0000, 0,0,0, 0);
    step(0,0,0,0,0); check("idle_after",  8'h00, 16'h0000, 0,0,0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
